uart_responder_tx: RTL and testbench
====================================

Name: uart_responder_tx

Overview:
- Transmit half of the UART responder: accepts bytes on a valid/ready interface, buffers them in a small FIFO, and serialises them onto txd as 8N1-style frames.
- The baud rate, parity and stop-bit options are set by parameters.
- Sits between the responder's command/response logic and the external UART pin.
- Runs in the single system clock domain (50 MHz nominal, 20 ns period).

Parameters:
- CLKS_PER_BIT, 434, clocks per bit period (434 gives 115200 baud at 50 MHz); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2 and >= 2.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  FIFO can accept a byte.
- txd  output  1  serial line; idles high.
- busy  output  1  a frame is in progress, or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is synchronous and active-high; the clock is clock and the reset is reset.
- While reset is sampled high, at the next edge:
  - txd=1, busy=0, fifo_count=0;
  - FIFO pointers cleared, FSM to IDLE, baud counter=0;
  - tx_ready=0 while reset is asserted, and 1 from the first edge after deassertion.
- Reset during a frame aborts the frame: txd=1 at the next edge and queued bytes are discarded.
- Handshake:
  - A push occurs on any edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count < FIFO_DEPTH), registered-state based.
  - When full, a pop in the same cycle does not enable a push; ready stays low that cycle.
  - tx_data is ignored when tx_valid=0.
- FIFO:
  - Circular, with a pointer wrap at FIFO_DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - fifo_count never exceeds FIFO_DEPTH and never underflows.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If fifo_count>0, pop the head into the shift register, load the baud counter, and go to START.
  - START: txd=0 for CLKS_PER_BIT clocks.
  - DATA: shift LSB first, one bit per CLKS_PER_BIT clocks, DATA_BITS bits, with a bit index counter.
  - PARITY (skipped when PARITY=0): even mode sends the XOR of the data bits; odd mode sends its inverse. Lasts CLKS_PER_BIT clocks.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT clocks. At the end, if the FIFO is non-empty, pop and go directly to START (no idle clock between frames); otherwise go to IDLE.
- txd is driven from a register, so there are no combinational glitches.
- Latency:
  - Push at edge N into an empty FIFO while IDLE: the pop occurs at edge N+1.
  - txd goes low at edge N+1, because the FSM register and txd register update together.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT clocks exactly.
- busy = (state != IDLE) || (fifo_count != 0).
- Bits above DATA_BITS do not exist; tx_data width equals DATA_BITS.

Test Plan:
1. CLKS_PER_BIT=4, 8N1; push 0x55 at edge N -> txd low from N+1 for 4 clocks, then bits 1,0,1,0,1,0,1,0 (4 clocks each), then high for 4. busy deasserts at edge N+41; total frame 40 clocks.
2. PARITY=1, push 0x07 -> parity bit 1. PARITY=2, push 0x07 -> parity bit 0. PARITY=1, push 0x03 -> parity bit 0. Frame length 44 clocks at CLKS_PER_BIT=4.
3. Push 0xA5 then 0x3C on consecutive cycles -> the second start bit begins on the clock immediately after the first frame's stop period ends, with zero extra idle. Serial data is LSB first: 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
4. FIFO_DEPTH=4, hold tx_valid=1 with 6 distinct bytes while transmitting:
   - tx_ready drops once count=4, with the first byte already popped, so 5 are accepted.
   - The 6th byte is accepted only after the next pop.
   - All 6 bytes are transmitted in order; fifo_count never exceeds 4.
5. Assert reset for 1 clock midway through the DATA bits of 0x0F with 2 bytes queued:
   - txd=1 and fifo_count=0 at the next edge, and txd stays idle.
   - tx_ready=1 after release.
   - A new push of 0x81 produces a clean frame.
6. STOP_BITS=2, CLKS_PER_BIT=4, push 0xFF, 0x00 back-to-back -> txd is high for exactly 8 clocks between the last data bit of 0xFF and the start bit of 0x00.

Source files
------------

// File: rtl/uart_responder_tx.sv
// UART transmit path: valid/ready byte intake, small circular FIFO,
// and a registered-output serialiser (start, data LSB first, parity, stop).
module uart_responder_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [AW:0]          count_q, count_d;
    logic                 ready_q;
    state_t               state_q;
    logic [BW-1:0]        baud_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 txd_q;

    logic                 push, pop, baud_done;
    logic [DATA_BITS-1:0] head;

    assign head      = mem[rd_q];
    assign baud_done = (baud_q == '0);
    assign push      = tx_valid && ready_q;
    // A pop happens when idle, or exactly at the end of the stop period
    // so that back-to-back frames have no idle clock between them.
    assign pop = (count_q != '0) &&
                 ((state_q == S_IDLE) || (state_q == S_STOP && baud_done));

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_q] <= tx_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_d;
            ready_q <= (count_d < DEPTH);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else if (pop) begin
            state_q <= S_START;
            txd_q   <= 1'b0;
            baud_q  <= BIT_LAST;
            idx_q   <= '0;
            shift_q <= head;
            par_q   <= (^head) ^ (PARITY == 2);
        end else if (state_q != S_IDLE) begin
            if (!baud_done) begin
                baud_q <= baud_q - 1'b1;
            end else begin
                unique case (state_q)
                    S_START: begin
                        state_q <= S_DATA;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        baud_q  <= BIT_LAST;
                    end
                    S_DATA: begin
                        if (idx_q != IDX_LAST) begin
                            idx_q   <= idx_q + 1'b1;
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            baud_q  <= BIT_LAST;
                        end else if (PARITY != 0) begin
                            state_q <= S_PAR;
                            txd_q   <= par_q;
                            baud_q  <= BIT_LAST;
                        end else begin
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
                            baud_q  <= STOP_LAST;
                        end
                    end
                    S_PAR: begin
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                        baud_q  <= STOP_LAST;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        txd_q   <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        txd_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_ready   = ready_q;
    assign txd        = txd_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_responder_tx.sv
// Bench for uart_responder_tx: four configurations at 4 clocks per bit,
// a per-instance expected-frame queue and serial-line receiver monitors.
module tb_uart_responder_tx;

    typedef struct {
        logic [7:0] d;
        int         gap;
    } ent_t;

    logic       clock;
    logic       rst;
    logic [7:0] data;
    logic       vld [4];
    logic       rdy [4];
    logic       txw [4];
    logic       bsy [4];
    logic [2:0] cnt [4];
    int         gp  [4];

    int pc [4] = '{0, 1, 2, 0};
    int sc [4] = '{1, 1, 1, 2};

    ent_t exq [4][$];
    int   npass = 0;
    int   ntot  = 0;

    uart_responder_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) d0 (
        .clock(clock), .reset(rst), .tx_data(data), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .txd(txw[0]), .busy(bsy[0]), .fifo_count(cnt[0]));
    uart_responder_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) d1 (
        .clock(clock), .reset(rst), .tx_data(data), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .txd(txw[1]), .busy(bsy[1]), .fifo_count(cnt[1]));
    uart_responder_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) d2 (
        .clock(clock), .reset(rst), .tx_data(data), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .txd(txw[2]), .busy(bsy[2]), .fifo_count(cnt[2]));
    uart_responder_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) d3 (
        .clock(clock), .reset(rst), .tx_data(data), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .txd(txw[3]), .busy(bsy[3]), .fifo_count(cnt[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input int got, input int exp);
        ntot++;
        if (got !== exp)
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        else
            npass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected entries are queued at each accepted handshake.
    always @(posedge clock) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (vld[k] && rdy[k]) begin
                    ent_t e;
                    e.d   = data;
                    e.gap = gp[k];
                    exq[k].push_back(e);
                end
            end
        end
    end

    task automatic mon(input int k);
        int         nb, idle;
        logic [11:0] got, exp, mask;
        bit         ok, ab;
        ent_t       e;
        nb   = 1 + 8 + ((pc[k] != 0) ? 1 : 0) + sc[k];
        mask = 12'((1 << nb) - 1);
        idle = 1000;
        forever begin
            @(negedge clock);
            if (rst || txw[k]) begin
                if (!rst) idle++;
                continue;
            end
            got = '0;
            ok  = 1'b1;
            ab  = 1'b0;
            for (int i = 0; i < nb * 4; i++) begin
                if (i > 0) @(negedge clock);
                if (rst) begin
                    ab = 1'b1;
                    break;
                end
                if (i % 4 == 0) got[i / 4] = txw[k];
                else if (txw[k] !== got[i / 4]) ok = 1'b0;
            end
            if (ab) begin
                idle = 1000;
                continue;
            end
            if (exq[k].size() == 0) begin
                chk($sformatf("unexpected_frame%0d", k), int'(got & mask), 0);
            end else begin
                e = exq[k].pop_front();
                exp    = '1;
                exp[0] = 1'b0;
                for (int i = 0; i < 8; i++) exp[1 + i] = e.d[i];
                if (pc[k] == 1) exp[9] = ^e.d;
                if (pc[k] == 2) exp[9] = ~^e.d;
                chk($sformatf("frame%0d_bits", k), int'(got & mask), int'(exp & mask));
                chk($sformatf("frame%0d_bitlen", k), int'(ok), 1);
                if (e.gap >= 0)
                    chk($sformatf("frame%0d_gap", k), idle, e.gap);
            end
            idle = 0;
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);
    initial mon(3);

    task automatic wait_idle(input int k, output int n);
        n = 0;
        while (bsy[k] && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic push1(input int k, input logic [7:0] b);
        vld[k] = 1'b1;
        data   = b;
        tick();
        vld[k] = 1'b0;
    endtask

    int n, r, idx, acc_low, mx, guard, sixth;
    logic [7:0] bytes6 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    initial begin
        rst  = 1'b1;
        data = '0;
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0;
            gp[k]  = -1;
        end
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_txd%0d", k), int'(txw[k]), 1);
            chk($sformatf("rst_busy%0d", k), int'(bsy[k]), 0);
            chk($sformatf("rst_count%0d", k), int'(cnt[k]), 0);
            chk($sformatf("rst_ready%0d", k), int'(rdy[k]), 0);
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++)
            chk($sformatf("post_rst_ready%0d", k), int'(rdy[k]), 1);

        // 8N1 0x55: start at N+1, alternating bits, busy drops at N+41
        push1(0, 8'h55);
        chk("t1_txd_N", int'(txw[0]), 1);
        chk("t1_busy_N", int'(bsy[0]), 1);
        for (int c = 1; c <= 41; c++) begin
            tick();
            if (c == 1)  chk("t1_start", int'(txw[0]), 0);
            if (c == 4)  chk("t1_start_end", int'(txw[0]), 0);
            if (c == 5)  chk("t1_bit0", int'(txw[0]), 1);
            if (c == 9)  chk("t1_bit1", int'(txw[0]), 0);
            if (c == 33) chk("t1_bit7", int'(txw[0]), 0);
            if (c == 37) chk("t1_stop", int'(txw[0]), 1);
            if (c == 40) chk("t1_busy_40", int'(bsy[0]), 1);
        end
        chk("t1_busy_41", int'(bsy[0]), 0);
        repeat (2) tick();

        // Parity: 0x07 even->1, odd->0; 0x03 even->0; 44-clock frames
        vld[1] = 1'b1;
        vld[2] = 1'b1;
        data   = 8'h07;
        tick();
        vld[1] = 1'b0;
        vld[2] = 1'b0;
        wait_idle(1, n);
        chk("t2_len_even", n, 45);
        wait_idle(2, n);
        push1(1, 8'h03);
        wait_idle(1, n);
        chk("t2_len_even2", n, 45);
        repeat (2) tick();

        // Back-to-back 0xA5, 0x3C with no idle between frames
        vld[0] = 1'b1;
        data   = 8'hA5;
        tick();
        data  = 8'h3C;
        gp[0] = 0;
        tick();
        vld[0] = 1'b0;
        gp[0]  = -1;
        wait_idle(0, n);
        chk("t3_len", n, 80);
        repeat (2) tick();

        // Two stop bits, 0xFF then 0x00 back-to-back
        vld[3] = 1'b1;
        data   = 8'hFF;
        tick();
        data  = 8'h00;
        gp[3] = 0;
        tick();
        vld[3] = 1'b0;
        gp[3]  = -1;
        wait_idle(3, n);
        chk("t6_len", n, 88);
        repeat (2) tick();

        // FIFO fill with valid held: 5 accepted, 6th after next pop
        vld[0]  = 1'b1;
        data    = bytes6[0];
        idx     = 0;
        acc_low = -1;
        mx      = 0;
        guard   = 0;
        sixth   = -1;
        while (idx < 6 && guard < 400) begin
            r = int'(rdy[0]);
            tick();
            guard++;
            if (r != 0) begin
                idx++;
                if (idx < 6) data = bytes6[idx];
                else sixth = guard;
            end
            if (int'(cnt[0]) > mx) mx = int'(cnt[0]);
            if (!rdy[0] && acc_low < 0) acc_low = idx;
        end
        vld[0] = 1'b0;
        chk("t4_accepted", idx, 6);
        chk("t4_accept_before_full", acc_low, 5);
        chk("t4_sixth_edge", sixth, 43);
        wait_idle(0, n);
        if (int'(cnt[0]) > mx) mx = int'(cnt[0]);
        chk("t4_max_count", mx, 4);
        repeat (2) tick();

        // Reset mid-frame with two bytes queued
        vld[0] = 1'b1;
        data   = 8'h0F;
        tick();
        data = 8'hAA;
        tick();
        data = 8'hBB;
        tick();
        vld[0] = 1'b0;
        repeat (12) tick();
        chk("t5_count_pre", int'(cnt[0]), 2);
        rst = 1'b1;
        tick();
        chk("t5_rst_txd", int'(txw[0]), 1);
        chk("t5_rst_count", int'(cnt[0]), 0);
        chk("t5_rst_busy", int'(bsy[0]), 0);
        chk("t5_rst_ready", int'(rdy[0]), 0);
        for (int k = 0; k < 4; k++) exq[k].delete();
        rst = 1'b0;
        tick();
        chk("t5_ready_after", int'(rdy[0]), 1);
        r = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!txw[0] || bsy[0]) r++;
        end
        chk("t5_stays_idle", r, 0);
        push1(0, 8'h81);
        wait_idle(0, n);
        chk("t5_new_len", n, 41);
        repeat (4) tick();

        for (int k = 0; k < 4; k++)
            chk($sformatf("queue_drained%0d", k), exq[k].size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
